// File: rtl/i2c_reg_arbiter_if.sv
// Bus bundle for i2c_reg_arbiter: both requester ports, the RAM port and status.
// slave = arbiter view; master = requesters plus the RAM model.
interface i2c_reg_arbiter_if #(
    parameter int unsigned AW = 6
);
    logic          i2c_req;
    logic          i2c_wr;
    logic [15:0]   i2c_addr;
    logic [7:0]    i2c_wdata;
    logic          i2c_ack;
    logic [7:0]    i2c_rdata;

    logic          usr_req;
    logic          usr_wr;
    logic [15:0]   usr_addr;
    logic [7:0]    usr_wdata;
    logic          usr_ack;
    logic [7:0]    usr_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [6:0]    dev_addr;
    logic          addr_err;
    logic          busy;

    modport slave (
        input  i2c_req, i2c_wr, i2c_addr, i2c_wdata,
        input  usr_req, usr_wr, usr_addr, usr_wdata,
        input  mem_rdata,
        output i2c_ack, i2c_rdata, usr_ack, usr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output dev_addr, addr_err, busy
    );

    modport master (
        output i2c_req, i2c_wr, i2c_addr, i2c_wdata,
        output usr_req, usr_wr, usr_addr, usr_wdata,
        output mem_rdata,
        input  i2c_ack, i2c_rdata, usr_ack, usr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  dev_addr, addr_err, busy
    );
endinterface

// File: rtl/i2c_reg_arbiter.sv
// Round-robin arbiter/sequencer sharing one register RAM between the I2C slave
// and the user port; owns the device-address register at address 0x0000.
module i2c_reg_arbiter #(
    parameter int unsigned NUM_REGS     = 64,
    parameter logic [6:0]  DEF_DEV_ADDR = 7'h36
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    i2c_reg_arbiter_if.slave bus
);
    localparam int unsigned AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [16:0] LIMIT = 17'(NUM_REGS);

    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] ISSUE = 4'b0010;
    localparam logic [3:0] CAPT  = 4'b0100;
    localparam logic [3:0] DONE  = 4'b1000;

    logic [3:0]    r_state;
    logic          r_prio_i2c;
    logic          r_gnt_usr;
    logic          r_wr;
    logic [15:0]   r_addr;
    logic [7:0]    r_wdata;
    logic          r_i2c_ack, r_usr_ack;
    logic [7:0]    r_i2c_rdata, r_usr_rdata;
    logic          r_mem_en, r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_wdata;
    logic [6:0]    r_dev_addr;
    logic          r_addr_err;
    logic          r_busy;

    logic          w_req_any;
    logic          w_gnt_usr;
    logic          w_wr;
    logic [15:0]   w_addr;
    logic [7:0]    w_wdata;
    logic          w_in_rng;
    logic          w_r_in_rng;
    logic [7:0]    w_rd_src;

    assign w_req_any  = bus.i2c_req | bus.usr_req;
    assign w_gnt_usr  = bus.usr_req & (~bus.i2c_req | ~r_prio_i2c);
    assign w_wr       = w_gnt_usr ? bus.usr_wr    : bus.i2c_wr;
    assign w_addr     = w_gnt_usr ? bus.usr_addr  : bus.i2c_addr;
    assign w_wdata    = w_gnt_usr ? bus.usr_wdata : bus.i2c_wdata;
    assign w_in_rng   = ({1'b0, w_addr} < LIMIT);
    assign w_r_in_rng = ({1'b0, r_addr} < LIMIT);
    // Address 0 reads come from the register, since RAM contents are not reset
    assign w_rd_src   = (r_addr == '0) ? {1'b0, r_dev_addr} :
                        w_r_in_rng     ? bus.mem_rdata      : 8'hFF;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_prio_i2c  <= 1'b1;
            r_gnt_usr   <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_i2c_ack   <= 1'b0;
            r_usr_ack   <= 1'b0;
            r_i2c_rdata <= '0;
            r_usr_rdata <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_dev_addr  <= DEF_DEV_ADDR;
            r_addr_err  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_state    <= ISSUE;
                        r_busy     <= 1'b1;
                        r_gnt_usr  <= w_gnt_usr;
                        r_prio_i2c <= w_gnt_usr;
                        r_wr       <= w_wr;
                        r_addr     <= w_addr;
                        r_wdata    <= w_wdata;
                        // RAM strobe is registered here so it is live during ISSUE
                        r_mem_en   <= w_in_rng & (w_wr | (w_addr != '0));
                        r_mem_we   <= w_in_rng & w_wr;
                        if (w_in_rng) begin
                            r_mem_addr  <= w_addr[AW-1:0];
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                ISSUE: begin
                    r_state  <= CAPT;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (r_wr && (r_addr == '0))
                        r_dev_addr <= r_wdata[6:0];
                end
                CAPT: begin
                    r_state    <= DONE;
                    r_addr_err <= ~w_r_in_rng;
                    if (r_gnt_usr) begin
                        r_usr_ack <= 1'b1;
                        if (!r_wr) r_usr_rdata <= w_rd_src;
                    end else begin
                        r_i2c_ack <= 1'b1;
                        if (!r_wr) r_i2c_rdata <= w_rd_src;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_i2c_ack  <= 1'b0;
                    r_usr_ack  <= 1'b0;
                    r_addr_err <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i2c_ack   = r_i2c_ack;
    assign bus.i2c_rdata = r_i2c_rdata;
    assign bus.usr_ack   = r_usr_ack;
    assign bus.usr_rdata = r_usr_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.dev_addr  = r_dev_addr;
    assign bus.addr_err  = r_addr_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter with a behavioural single-port RAM
// and hand-computed expectations checked by immediate assertions.
module tb_i2c_reg_arbiter;
    logic sys_clk;
    logic sys_rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   n_en;
    int   n_we;
    int   n_uack;

    i2c_reg_arbiter_if #(.AW(6)) bus ();

    i2c_reg_arbiter #(.NUM_REGS(64), .DEF_DEV_ADDR(7'h36)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    logic [7:0] ram [0:63];
    always @(posedge sys_clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (bus.mem_en) n_en <= n_en + 1;
        if (bus.mem_en && bus.mem_we) n_we <= n_we + 1;
        if (bus.usr_ack) n_uack <= n_uack + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // side: 0 = I2C, 1 = user. Raises req at a negedge (cycle 0), waits for ack.
    task automatic access(input bit side, input bit wr, input logic [15:0] addr,
                          input logic [7:0] wdata, output logic [7:0] rdata,
                          output int lat, output logic err);
        int c0;
        bit got;
        @(negedge sys_clk);
        if (side) begin
            bus.usr_req = 1'b1; bus.usr_wr = wr; bus.usr_addr = addr; bus.usr_wdata = wdata;
        end else begin
            bus.i2c_req = 1'b1; bus.i2c_wr = wr; bus.i2c_addr = addr; bus.i2c_wdata = wdata;
        end
        c0 = cyc; got = 1'b0; lat = -1; rdata = 'x; err = 1'bx;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge sys_clk);
            if (side ? bus.usr_ack : bus.i2c_ack) begin
                got = 1'b1;
                lat = cyc - c0;
                rdata = side ? bus.usr_rdata : bus.i2c_rdata;
                err = bus.addr_err;
            end
        end
        bus.i2c_req = 1'b0;
        bus.usr_req = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
    endtask

    logic [7:0] rd;
    int         lat;
    logic       err;
    int         e0, w0, u0, c0, k;
    bit         sides [4];
    int         acyc  [4];
    logic [7:0] ards  [4];

    initial begin
        n_vec = 0; n_err = 0; n_en = 0; n_we = 0; n_uack = 0; cyc = 0;
        bus.i2c_req = 0; bus.i2c_wr = 0; bus.i2c_addr = '0; bus.i2c_wdata = '0;
        bus.usr_req = 0; bus.usr_wr = 0; bus.usr_addr = '0; bus.usr_wdata = '0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_i2c_ack", 32'(bus.i2c_ack), 32'd0);
        check("rst_usr_ack", 32'(bus.usr_ack), 32'd0);
        check("rst_mem_en",  32'(bus.mem_en),  32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_dev",     32'(bus.dev_addr), 32'h36);
        check("rst_i2c_rd",  32'(bus.i2c_rdata), 32'h0);
        sys_rst_n = 1'b1;

        // I2C read of 0x0000: register source, no RAM strobe
        e0 = n_en;
        access(0, 0, 16'h0000, 8'h00, rd, lat, err);
        check("rd0_lat",   32'(lat), 32'd3);
        check("rd0_data",  32'(rd), 32'h36);
        check("rd0_noen",  32'(n_en - e0), 32'd0);
        check("rd0_err",   32'(err), 32'd0);

        // I2C write then user read of the same address
        w0 = n_we;
        access(0, 1, 16'h0005, 8'h19, rd, lat, err);
        check("wr5_lat",   32'(lat), 32'd3);
        check("wr5_we",    32'(n_we - w0), 32'd1);
        check("wr5_rdhold", 32'(bus.i2c_rdata), 32'h36);
        e0 = n_en; w0 = n_we;
        access(1, 0, 16'h0005, 8'h00, rd, lat, err);
        check("rd5_data",  32'(rd), 32'h19);
        check("rd5_en",    32'(n_en - e0), 32'd1);
        check("rd5_nowe",  32'(n_we - w0), 32'd0);

        // Both sides requesting continuously: grants alternate starting with I2C
        @(negedge sys_clk);
        bus.i2c_req = 1; bus.i2c_wr = 0; bus.i2c_addr = 16'h0005;
        bus.usr_req = 1; bus.usr_wr = 0; bus.usr_addr = 16'h0005;
        c0 = cyc; k = 0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            @(negedge sys_clk);
            if (bus.i2c_ack) begin
                sides[k] = 0; acyc[k] = cyc; ards[k] = bus.i2c_rdata; k++;
            end else if (bus.usr_ack) begin
                sides[k] = 1; acyc[k] = cyc; ards[k] = bus.usr_rdata; k++;
            end
        end
        bus.i2c_req = 0; bus.usr_req = 0;
        check("rr_count", 32'(k), 32'd4);
        if (k == 4) begin
            check("rr_first_lat", 32'(acyc[0] - c0), 32'd3);
            for (int i = 0; i < 4; i++) begin
                check("rr_side", 32'(sides[i]), 32'(i % 2));
                check("rr_data", 32'(ards[i]), 32'h19);
                if (i > 0) check("rr_gap", 32'(acyc[i] - acyc[i-1]), 32'd4);
            end
        end

        // User write of the device-address register; visible after ISSUE
        @(negedge sys_clk);
        w0 = n_we;
        bus.usr_req = 1; bus.usr_wr = 1; bus.usr_addr = 16'h0000; bus.usr_wdata = 8'h78;
        @(negedge sys_clk);
        check("dev_in_issue", 32'(bus.dev_addr), 32'h36);
        check("mem_en_issue", 32'(bus.mem_en), 32'd1);
        @(negedge sys_clk);
        check("dev_in_capt",  32'(bus.dev_addr), 32'h78);
        @(negedge sys_clk);
        check("wr0_ack",      32'(bus.usr_ack), 32'd1);
        bus.usr_req = 0;
        check("wr0_we",       32'(n_we - w0), 32'd1);
        access(0, 0, 16'h0000, 8'h00, rd, lat, err);
        check("rd0_new",      32'(rd), 32'h78);

        // Out-of-range write and read
        e0 = n_en;
        access(0, 1, 16'h0040, 8'hAA, rd, lat, err);
        check("oor_wr_noen",  32'(n_en - e0), 32'd0);
        check("oor_wr_err",   32'(err), 32'd1);
        check("oor_wr_rdh",   32'(rd), 32'h78);
        access(0, 0, 16'h0040, 8'h00, rd, lat, err);
        check("oor_rd_data",  32'(rd), 32'hFF);
        check("oor_rd_err",   32'(err), 32'd1);
        check("oor_rd_noen",  32'(n_en - e0), 32'd0);

        // Reset asserted during CAPT of a user read
        @(negedge sys_clk);
        u0 = n_uack;
        bus.usr_req = 1; bus.usr_wr = 0; bus.usr_addr = 16'h0005;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mr_usr_ack",   32'(bus.usr_ack), 32'd0);
        check("mr_busy",      32'(bus.busy), 32'd0);
        check("mr_mem_en",    32'(bus.mem_en), 32'd0);
        check("mr_dev",       32'(bus.dev_addr), 32'h36);
        check("mr_usr_rd",    32'(bus.usr_rdata), 32'h0);
        check("mr_i2c_rd",    32'(bus.i2c_rdata), 32'h0);
        check("mr_addr_err",  32'(bus.addr_err), 32'd0);
        repeat (2) @(negedge sys_clk);
        bus.usr_req = 0;
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("mr_no_uack",   32'(n_uack - u0), 32'd0);
        check("mr_idle",      32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_reg_arbiter.md
# i2c_reg_arbiter

Arbiter and sequencer for the I2C slave's register space. It shares one single-port register RAM between two requesters: the i2c_slave register port and a local fabric (user) port. Requests are serialised with round-robin priority, and the block owns the device-address register at 0x0000, which i2c_slave uses for address matching. It sits between u_i2c_slave, the user logic and the register RAM instance.

## Interface
- NUM_REGS, 64, implemented register count; valid addresses 0 .. NUM_REGS-1 (NUM_REGS ≤ 65536, power of two)
- DEF_DEV_ADDR, 7'h36, reset value of the device-address register
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i2c_req  in  1  I2C-side request, level, held until i2c_ack
- i2c_wr  in  1  1 = write, 0 = read; stable while i2c_req=1
- i2c_addr  in  16  register address; stable while i2c_req=1
- i2c_wdata  in  8  write data; stable while i2c_req=1
- i2c_ack  out  1  one-cycle completion strobe
- i2c_rdata  out  8  read data, valid while i2c_ack=1, held afterwards
- usr_req / usr_wr / usr_addr / usr_wdata / usr_ack / usr_rdata  same as the i2c_* ports, for the user side
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  log2(NUM_REGS)  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid one cycle after mem_en
- dev_addr  out  7  current I2C device address, feeds i2c_slave
- addr_err  out  1  one-cycle pulse; the completed access was out of range
- busy  out  1  1 in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPT, DONE, one-hot. All transitions are unconditional except the one out of IDLE.
- IDLE: if any req=1, latch the winner's wr/addr/wdata and go to ISSUE. Otherwise stay in IDLE.
- Arbitration is round-robin on a 1-bit pointer prio_i2c (reset 1).
  - Both requests pending: grant the side prio_i2c points to.
  - One request pending: grant it.
  - On each grant, prio_i2c is set to point at the other side.
- ISSUE: if addr < NUM_REGS, mem_en=1, mem_we=wr, mem_addr=addr[log2(NUM_REGS)-1:0], mem_wdata=wdata. If addr ≥ NUM_REGS, there is no RAM access.
- Write to 0x0000: dev_addr ← wdata[6:0] at the end of ISSUE. The RAM is also written.
- CAPT: capture read data into the granted side's rdata register and set that side's ack register. The read-data source is:
  - addr 0x0000: {1'b0, dev_addr}. The RAM is not read for this, because RAM contents are not reset.
  - in range: mem_rdata.
  - out of range: 8'hFF. addr_err is set in this case (writes and reads).
  - Writes leave rdata unchanged.
- DONE: ack=1 and addr_err valid for exactly this cycle. Go to IDLE.
- Requester rule: drop req on the clock edge at which it samples ack=1. A req that is still high in the following IDLE cycle is treated as a new request.
- Ordering: accesses are strictly serialised in grant order. A read following another side's write to the same address returns the new data.
- The non-granted side's ack/rdata are untouched.

## Timing
- Reset values:
  - state IDLE
  - i2c_ack, usr_ack, mem_en, mem_we, addr_err, busy = 0
  - i2c_rdata, usr_rdata, mem_addr, mem_wdata = 0
  - dev_addr = DEF_DEV_ADDR
  - prio_i2c = 1
- Reset mid-operation: the in-flight access is abandoned, no ack is issued, and no RAM write occurs after assertion. An already-completed dev_addr write is overwritten by DEF_DEV_ADDR.
- Latency: req seen in IDLE at cycle 0 → mem_en at cycle 1 → ack at cycle 3. The next grant is possible at cycle 4 (4-cycle turnaround).
- All outputs are registered. No combinational path from the *_req inputs to any output.
- Worst-case wait, with both sides continuously requesting, is 8 cycles, well inside one 400 kHz SCL bit (125 cycles).

## Test plan
- Reset, then I2C read 0x0000 → i2c_ack at cycle 3, i2c_rdata=8'h36, no mem_en.
- I2C write 0x0005=8'h19, then user read 0x0005 → usr_rdata=8'h19, mem_we pulse exactly once.
- i2c_req and usr_req raised in the same cycle, each continuously re-requesting → grants alternate I2C, usr, I2C, usr; each ack is 4 cycles after the previous one.
- User write 0x0000=8'h78 → dev_addr=7'h78 from the cycle after ISSUE; a subsequent I2C read of 0x0000 returns 8'h78.
- I2C write 0x0040=8'hAA with NUM_REGS=64 → no mem_en, addr_err and i2c_ack in the same cycle. Read of 0x0040 → 8'hFF, addr_err=1.
- Assert sys_rst_n=0 during CAPT of a user read → usr_ack never pulses, all outputs take their reset values, dev_addr=7'h36.
